// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI slave port: FSM encoding, byte width and
// the fill byte shifted out when the TX holding register is empty at load time.
package spi_slave_port_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_W);

    localparam logic [BYTE_W-1:0] UNDERRUN_FILL = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_slave_port_sync_edge.sv
// spi_sync_edge: N-stage synchronizer for an asynchronous pin plus one extra
// registered copy, giving a clean level and single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer and keep a delayed copy of the last stage
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode-0 slave with a one-byte TX holding register and a
// valid/ready RX byte output. Optional sticky error flags are built when the
// macro SPI_SLAVE_ERR_EN is defined.
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              spi_clk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              busy_o
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic              rx_overrun_o,
    output logic              tx_underrun_o,
    input  logic              err_clr_i
`endif
);

    localparam int SETTLE   = SYNC_STAGES + 1;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [BYTE_W-1:0]     tx_shift_q;
    logic [BYTE_W-1:0]     rx_shift_q;
    logic [BYTE_W-1:0]     rx_next;
    logic [BYTE_W-1:0]     rx_data_q;
    logic                  rx_valid_q;
    logic [BYTE_W-1:0]     hold_data_q;
    logic                  hold_full_q;
    logic [BYTE_W-1:0]     load_value;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SETTLE_W-1:0]   settle_cnt_q;
    logic                  armed_q;

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_bit;
    logic load_take;
    logic shift_active;
    logic byte_done;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .async_i (spi_clk_i),
        .level_o (sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .async_i (spi_cs_n_i),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // MOSI only needs a plain synchronizer; its last stage lines up with the SCLK edge pulse
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        end
    end

    assign mosi_bit     = mosi_sync_q[SYNC_STAGES-1];
    assign load_value   = hold_full_q ? hold_data_q : UNDERRUN_FILL;
    assign load_take    = (state_q == ST_LOAD) && !cs_level;
    assign shift_active = (state_q == ST_SHIFT) && !cs_level;
    assign rx_next      = {rx_shift_q[BYTE_W-2:0], mosi_bit};
    assign byte_done    = shift_active && sclk_rise && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));

    // Arm frame detection only once the synchronizers reflect a real deselected bus, so a
    // chip select still low when reset releases cannot be mistaken for a new frame
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            settle_cnt_q <= '0;
            armed_q      <= 1'b0;
        end else begin
            if (settle_cnt_q != SETTLE_W'(SETTLE)) begin
                settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
            end else if (cs_level) begin
                armed_q <= 1'b1;
            end
            if (cs_rise) begin
                armed_q <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a frame starts on a chip-select fall with SCLK idle low, deselect always wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall && armed_q && !sclk_level) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (byte_done) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
        if (cs_level) begin
            state_d = ST_IDLE;
        end
    end

    // MISO shows the byte being loaded straight away, then the MSB of the shift register
    always_comb begin
        spi_miso_o = MISO_IDLE;
        case (state_q)
            ST_LOAD:  spi_miso_o = load_value[BYTE_W-1];
            ST_SHIFT: spi_miso_o = tx_shift_q[BYTE_W-1];
            default:  spi_miso_o = MISO_IDLE;
        endcase
    end

    // Shift datapath: sample MOSI on SCLK rise, advance MISO on SCLK fall except the fall
    // that trails the last bit of the previous byte (bit counter already back at zero)
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
        end else if (cs_level) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
        end else if (load_take) begin
            tx_shift_q <= load_value;
        end else if (shift_active) begin
            if (sclk_rise) begin
                rx_shift_q <= rx_next;
                bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
            end
            if (sclk_fall && (bit_cnt_q != '0)) begin
                tx_shift_q <= {tx_shift_q[BYTE_W-2:0], 1'b0};
            end
        end
    end

    // TX holding register: a LOAD empties it, an accepted write fills it
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            if (load_take) begin
                hold_full_q <= 1'b0;
            end
            if (tx_valid_i && tx_ready_o) begin
                hold_full_q <= 1'b1;
                hold_data_q <= tx_data_i;
            end
        end
    end

    // RX output register: a completed byte always lands, even over unread data
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (byte_done) begin
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
        end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign tx_ready_o = ~hold_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q != ST_IDLE);

`ifdef SPI_SLAVE_ERR_EN
    logic rx_overrun_q;
    logic tx_underrun_q;

    // Sticky error flags; a new event in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            if (err_clr_i) begin
                rx_overrun_q  <= 1'b0;
                tx_underrun_q <= 1'b0;
            end
            if (byte_done && rx_valid_q && !rx_ready_i) begin
                rx_overrun_q <= 1'b1;
            end
            if (load_take && !hold_full_q) begin
                tx_underrun_q <= 1'b1;
            end
        end
    end

    assign rx_overrun_o  = rx_overrun_q;
    assign tx_underrun_o = tx_underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_port.sv
// Testbench for spi_slave_port: acts as a mode-0 SPI master, feeds the TX
// holding register from a queue and collects RX handshakes into a queue.
// Error-flag checks are compiled in when SPI_SLAVE_ERR_EN is defined.
module tb_spi_slave_port;

    logic       clk_i      = 1'b0;
    logic       rstn_i     = 1'b0;
    logic       spi_clk_i  = 1'b0;
    logic       spi_cs_n_i = 1'b1;
    logic       spi_mosi_i = 1'b0;
    logic       spi_miso_o;
    logic [7:0] tx_data_i  = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i = 1'b0;
    logic       busy_o;
`ifdef SPI_SLAVE_ERR_EN
    logic       rx_overrun_o;
    logic       tx_underrun_o;
    logic       err_clr_i  = 1'b0;
`endif

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic       preload;
        logic [7:0] expMiso;
        logic [7:0] expRx;
        logic       expUnderrun;
    } vec_t;

    vec_t       vectors[5];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] mosiBytes[$];
    logic [7:0] expMisoBytes[$];
    logic [7:0] gotMiso[$];
    int         assertCount = 0;
    int         failCount   = 0;
    int         rxRiseCount = 0;
    logic       rxValidPrev = 1'b0;

    spi_slave_port #(.SYNC_STAGES(2), .MISO_IDLE(1'b0)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .spi_clk_i    (spi_clk_i),
        .spi_cs_n_i   (spi_cs_n_i),
        .spi_mosi_i   (spi_mosi_i),
        .spi_miso_o   (spi_miso_o),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .busy_o       (busy_o)
`ifdef SPI_SLAVE_ERR_EN
        ,
        .rx_overrun_o (rx_overrun_o),
        .tx_underrun_o(tx_underrun_o),
        .err_clr_i    (err_clr_i)
`endif
    );

    // 100 MHz system clock
    always #5 clk_i = ~clk_i;

    // TX feeder: writes the next queued byte whenever the holding register is empty
    initial begin
        forever begin
            @(negedge clk_i);
            if (rstn_i && tx_ready_o && (txq.size() > 0)) begin
                tx_data_i  = txq[0];
                tx_valid_i = 1'b1;
                @(negedge clk_i);
                void'(txq.pop_front());
                tx_valid_i = 1'b0;
            end
        end
    end

    // RX monitor: records each byte handed over and counts rx_valid rising edges
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (rx_valid_o && rx_ready_i) rxq.push_back(rx_data_o);
            if (rx_valid_o && !rxValidPrev) rxRiseCount++;
            rxValidPrev = rx_valid_o;
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Half an SCLK period is 8 system clocks
    task automatic halfBit();
        waitCycles(8);
    endtask

    task automatic csLow();
        spi_cs_n_i = 1'b0;
        halfBit();
    endtask

    task automatic csHigh();
        halfBit();
        spi_cs_n_i = 1'b1;
        halfBit();
        halfBit();
    endtask

    // Clock out nbits of mosi (MSB first) and return the MISO bits the master sampled
    task automatic spiBits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = mosi[7-i];
            halfBit();
            miso = {miso[6:0], spi_miso_o};
            spi_clk_i = 1'b1;
            halfBit();
            spi_clk_i = 1'b0;
        end
    endtask

    task automatic waitRxValid(input int budget);
        int n = 0;
        while (!rx_valid_o && (n < budget)) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic errClear();
`ifdef SPI_SLAVE_ERR_EN
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
`endif
    endtask

    task automatic drainRx();
        rx_ready_i = 1'b1;
        waitCycles(3);
        rx_ready_i = 1'b0;
        waitCycles(1);
        rxq.delete();
    endtask

    // One table vector: optional preload, one full byte split 4+4 so the underrun flag
    // can be inspected before the trailing reload at the end of the byte
    task automatic applyStimulus(input vec_t v, output logic [7:0] misoGot);
        logic [7:0] m1, m2;
        errClear();
        if (v.preload) begin
            txq.push_back(v.tx);
            waitCycles(4);
        end
        csLow();
        spiBits(v.mosi, 4, m1);
`ifdef SPI_SLAVE_ERR_EN
        checkOutput("vec_underrun_mid", tx_underrun_o, v.expUnderrun);
`endif
        spiBits({v.mosi[3:0], 4'h0}, 4, m2);
        csHigh();
        misoGot = {m1[3:0], m2[3:0]};
    endtask

    initial begin
        logic [7:0] misoGot;
        logic [7:0] b;
        int         riseBefore;
        int         len;
        int         ntx;

        vectors[0] = '{8'h3C, 8'hA5, 1'b1, 8'hA5, 8'h3C, 1'b0};
        vectors[1] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b1};
        vectors[2] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 8'h00, 1'b0};
        vectors[3] = '{8'h81, 8'h7E, 1'b1, 8'h7E, 8'h81, 1'b0};
        vectors[4] = '{8'hC3, 8'h00, 1'b0, 8'h00, 8'hC3, 1'b1};

        // Reset values
        waitCycles(3);
        checkOutput("rst_tx_ready", tx_ready_o, 1'b1);
        checkOutput("rst_rx_valid", rx_valid_o, 1'b0);
        checkOutput("rst_rx_data", rx_data_o, 8'h00);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_miso", spi_miso_o, 1'b0);
`ifdef SPI_SLAVE_ERR_EN
        checkOutput("rst_overrun", rx_overrun_o, 1'b0);
        checkOutput("rst_underrun", tx_underrun_o, 1'b0);
`endif
        rstn_i = 1'b1;
        waitCycles(10);

        // Table-driven single-byte frames
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vectors[i], misoGot);
            waitRxValid(20);
            checkOutput($sformatf("vec%0d_miso", i), misoGot, vectors[i].expMiso);
            checkOutput($sformatf("vec%0d_rx_valid", i), rx_valid_o, 1'b1);
            checkOutput($sformatf("vec%0d_rx_data", i), rx_data_o, vectors[i].expRx);
            checkOutput($sformatf("vec%0d_idle_miso", i), spi_miso_o, 1'b0);
            drainRx();
            checkOutput($sformatf("vec%0d_rx_cleared", i), rx_valid_o, 1'b0);
        end

        // Three-byte burst with the feeder refilling the holding register between bytes
        rx_ready_i = 1'b1;
        rxq.delete();
        riseBefore = rxRiseCount;
        txq.push_back(8'hC0); txq.push_back(8'hC1); txq.push_back(8'hC2);
        waitCycles(4);
        csLow();
        spiBits(8'h11, 8, misoGot); checkOutput("burst_miso0", misoGot, 8'hC0);
        spiBits(8'h22, 8, misoGot); checkOutput("burst_miso1", misoGot, 8'hC1);
        spiBits(8'h33, 8, misoGot); checkOutput("burst_miso2", misoGot, 8'hC2);
        csHigh();
        checkOutput("burst_rx_count", rxq.size(), 3);
        checkOutput("burst_rise_count", rxRiseCount - riseBefore, 3);
        if (rxq.size() == 3) begin
            checkOutput("burst_rx0", rxq[0], 8'h11);
            checkOutput("burst_rx1", rxq[1], 8'h22);
            checkOutput("burst_rx2", rxq[2], 8'h33);
        end
        rxq.delete();
        rx_ready_i = 1'b0;

        // Overrun: two bytes, consumer not ready
        errClear();
        riseBefore = rxRiseCount;
        csLow();
        spiBits(8'h01, 8, misoGot);
        spiBits(8'h02, 8, misoGot);
        csHigh();
        checkOutput("ovr_rx_data", rx_data_o, 8'h02);
        checkOutput("ovr_rx_valid", rx_valid_o, 1'b1);
        checkOutput("ovr_rise_count", rxRiseCount - riseBefore, 1);
`ifdef SPI_SLAVE_ERR_EN
        checkOutput("ovr_flag", rx_overrun_o, 1'b1);
        errClear();
        checkOutput("ovr_flag_cleared", rx_overrun_o, 1'b0);
        checkOutput("unr_flag_cleared", tx_underrun_o, 1'b0);
`endif
        drainRx();

        // Chip select raised after 4 bits, then a full byte
        riseBefore = rxRiseCount;
        csLow();
        spiBits(8'hF0, 4, misoGot);
        csHigh();
        checkOutput("abort_busy", busy_o, 1'b0);
        checkOutput("abort_rx_valid", rx_valid_o, 1'b0);
        checkOutput("abort_no_rise", rxRiseCount - riseBefore, 0);
        csLow();
        spiBits(8'h5A, 8, misoGot);
        csHigh();
        checkOutput("abort_next_rx_data", rx_data_o, 8'h5A);
        checkOutput("abort_next_rise", rxRiseCount - riseBefore, 1);
        drainRx();

        // Reset mid-transfer with chip select still low
        txq.push_back(8'hA5); txq.push_back(8'h3C);
        waitCycles(4);
        csLow();
        spiBits(8'hE1, 5, misoGot);
        checkOutput("prerst_holding_full", tx_ready_o, 1'b0);
        rstn_i = 1'b0;
        waitCycles(2);
        checkOutput("midrst_tx_ready", tx_ready_o, 1'b1);
        checkOutput("midrst_rx_data", rx_data_o, 8'h00);
        checkOutput("midrst_rx_valid", rx_valid_o, 1'b0);
        checkOutput("midrst_busy", busy_o, 1'b0);
        checkOutput("midrst_miso", spi_miso_o, 1'b0);
        rstn_i = 1'b1;
        waitCycles(20);
        checkOutput("postrst_no_start", busy_o, 1'b0);
        spi_cs_n_i = 1'b1;
        waitCycles(16);
        csLow();
        spiBits(8'h77, 8, misoGot);
        csHigh();
        checkOutput("postrst_rx_data", rx_data_o, 8'h77);
        checkOutput("postrst_rx_valid", rx_valid_o, 1'b1);
        checkOutput("postrst_miso", misoGot, 8'h00);
        drainRx();

        // Random frames checked against a queue model: the k-th byte of a frame returns
        // the k-th supplied TX byte, or the fill byte once the supplied ones run out
        rx_ready_i = 1'b1;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 3);
            ntx = $urandom_range(0, len);
            mosiBytes.delete(); expMisoBytes.delete(); gotMiso.delete(); rxq.delete();
            for (int k = 0; k < len; k++) begin
                mosiBytes.push_back(8'($urandom));
                if (k < ntx) begin
                    b = 8'($urandom);
                    txq.push_back(b);
                    expMisoBytes.push_back(b);
                end else begin
                    expMisoBytes.push_back(8'h00);
                end
            end
            waitCycles(4);
            csLow();
            for (int k = 0; k < len; k++) begin
                spiBits(mosiBytes[k], 8, misoGot);
                gotMiso.push_back(misoGot);
            end
            csHigh();
            checkOutput($sformatf("rnd%0d_rx_count", f), rxq.size(), len);
            for (int k = 0; k < len; k++) begin
                checkOutput($sformatf("rnd%0d_miso%0d", f, k), gotMiso[k], expMisoBytes[k]);
                if (k < rxq.size())
                    checkOutput($sformatf("rnd%0d_rx%0d", f, k), rxq[k], mosiBytes[k]);
            end
        end
        rx_ready_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
